program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 17 +
 rtl/loader_addr_counter.sv | 42 ++++
 rtl/program_loader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the program loader slice.
//   loader_state_t  : session FSM encoding (IDLE=0, LOAD=1, DONE=2)
//   ADDR_W_DEFAULT  : default program address width
// ---------------------------------------------------------------------------
package program_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  localparam int ADDR_W_DEFAULT = 12;

endpackage

// File: rtl/loader_addr_counter.sv
// ---------------------------------------------------------------------------
// loader_addr_counter
// Write-address register for the program loader. Loads a start address and
// then steps by one per accepted byte, wrapping modulo 2^ADDR_W.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset (address -> 0)
//   load      in   capture loadValue (takes priority over enable)
//   enable    in   increment the address by one
//   loadValue in   address to load
//   addr      out  current write address
// ---------------------------------------------------------------------------
module loader_addr_counter
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              enable,
  input  logic [ADDR_W-1:0] loadValue,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] r_addr;

  // Address register: a new session load wins over a step; the natural
  // overflow of the adder gives the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
    end else if (load) begin
      r_addr <= loadValue;
    end else if (enable) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  assign addr = r_addr;

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Accepts {instr, operand} nibble pairs from a source and writes them as
// bytes into program memory starting at a captured address, counting down a
// captured length and keeping a mod-256 checksum. A session aborts with a
// sticky error if it would run past the top of the address space.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   start/startAddr/length session request and its parameters
//   instr/operand/inValid  source byte and its valid
//   inReady                loader accepts a pair (LOAD state only)
//   memAddr/memData/memWe  registered program memory write port
//   busy/done/error        session status
//   checksum               running sum of accepted bytes in this session
// ---------------------------------------------------------------------------
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [ADDR_W-1:0] length,
  input  logic [3:0]        instr,
  input  logic [3:0]        operand,
  input  logic              inValid,
  output logic              inReady,
  output logic [ADDR_W-1:0] memAddr,
  output logic [7:0]        memData,
  output logic              memWe,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        checksum
);

  loader_state_t r_state;
  loader_state_t w_nextState;

  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic [ADDR_W-1:0] r_memAddr;
  logic [7:0]        r_memData;
  logic              r_memWe;
  logic              r_error;
  logic [7:0]        r_checksum;

  logic              w_accept;
  logic              w_startAccept;
  logic              w_wrapAbort;
  logic              w_lastByte;
  logic [7:0]        w_byte;

  assign w_byte        = {instr, operand};
  assign w_accept      = (r_state == LOAD) && inValid;
  assign w_startAccept = (r_state == IDLE) && start;
  assign w_lastByte    = (r_remaining == ADDR_W'(1));
  // Writing the top address with bytes still owed would wrap to address 0,
  // so that byte is the last one written and the session aborts.
  assign w_wrapAbort   = w_accept && (w_addr == {ADDR_W{1'b1}}) &&
                         (r_remaining > ADDR_W'(1));

  loader_addr_counter #(
    .ADDR_W(ADDR_W)
  ) u_addrCounter (
    .clk      (clk),
    .reset    (reset),
    .load     (w_startAccept),
    .enable   (w_accept),
    .loadValue(startAddr),
    .addr     (w_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: a zero-length start goes straight to DONE; DONE is
  // always a single cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = (length == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (w_accept && (w_lastByte || w_wrapAbort)) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Session datapath: the write port is registered one cycle behind the
  // acceptance and holds its address/data between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_memAddr   <= '0;
      r_memData   <= '0;
      r_memWe     <= 1'b0;
      r_remaining <= '0;
      r_checksum  <= '0;
      r_error     <= 1'b0;
    end else begin
      r_memWe <= w_accept;
      if (w_accept) begin
        r_memAddr   <= w_addr;
        r_memData   <= w_byte;
        r_remaining <= r_remaining - ADDR_W'(1);
        r_checksum  <= r_checksum + w_byte;
        if (w_wrapAbort) begin
          r_error <= 1'b1;
        end
      end else if (w_startAccept) begin
        r_remaining <= length;
        r_checksum  <= '0;
        r_error     <= 1'b0;
      end
    end
  end

  assign inReady  = (r_state == LOAD);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign memAddr  = r_memAddr;
  assign memData  = r_memData;
  assign memWe    = r_memWe;
  assign error    = r_error;
  assign checksum = r_checksum;

endmodule
